// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit with fixed 34-cycle latency
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;
  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_a, r_b, r_result;
  logic                r_sa, r_sb;
  logic [2*DATA_W-1:0] r_acc;
  logic                w_accept, w_s1, w_s2, w_na, w_nb;
  logic [DATA_W-1:0]   w_a_abs, w_b_abs, w_quo, w_rem, w_dvd, w_fix;
  logic [DATA_W:0]     w_sum, w_shl, w_diff;
  logic [2*DATA_W-1:0] w_acc_nxt, w_prod;
  logic [1:0]          w_state_nxt;
  always_comb begin
    w_accept    = i_start && !i_flush && (r_state == S_IDLE || r_state == S_DONE);
    w_s1        = i_op == 3'b001 || i_op == 3'b010 || i_op == 3'b100 || i_op == 3'b110;
    w_s2        = i_op == 3'b001 || i_op == 3'b100 || i_op == 3'b110;
    w_na        = w_s1 && i_rs1_data[DATA_W-1];
    w_nb        = w_s2 && i_rs2_data[DATA_W-1];
    w_a_abs     = w_na ? -i_rs1_data : i_rs1_data;
    w_b_abs     = w_nb ? -i_rs2_data : i_rs2_data;
    w_sum       = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_shl       = r_acc[2*DATA_W-1:DATA_W-1];
    w_diff      = w_shl - {1'b0, r_b};
    w_acc_nxt   = !r_op[2] ? {w_sum, r_acc[DATA_W-1:1]} :
                  w_diff[DATA_W] ? {w_shl[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0} :
                                   {w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
    w_prod      = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_quo       = (r_sa ^ r_sb) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    w_rem       = r_sa ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    w_dvd       = r_sa ? -r_a : r_a;
    w_fix       = !r_op[2] ? (r_op[1:0] == 2'b00 ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W]) :
                  r_b == '0 ? (r_op[1] ? w_dvd : '1) :
                  r_op[1] ? w_rem : w_quo;
    w_state_nxt = i_flush ? S_IDLE :
                  w_accept ? S_CALC :
                  r_state == S_CALC ? (r_cnt == CW'(DATA_W - 1) ? S_FIX : S_CALC) :
                  r_state == S_FIX ? S_DONE : S_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= i_op;
        r_a   <= w_a_abs;
        r_b   <= w_b_abs;
        r_sa  <= w_na;
        r_sb  <= w_nb;
        r_acc <= {{DATA_W{1'b0}}, i_op[2] ? w_a_abs : w_b_abs};
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_FIX && !i_flush) r_result <= w_fix;
      r_state <= w_state_nxt;
    end
  end
  assign o_busy   = r_state == S_CALC || r_state == S_FIX;
  assign o_valid  = r_state == S_DONE;
  assign o_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic        i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_flush = 1'b0;
  logic [2:0]  i_op = '0;
  logic [31:0] i_rs1_data = '0, i_rs2_data = '0;
  logic        o_busy, o_valid;
  logic [31:0] o_result;
  int          n_vec = 0, n_err = 0;
  muldiv_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_flush(i_flush),
    .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge i_clk);
    #1;
  endtask
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int lat, nbusy;
    lat = 0;
    nbusy = 0;
    i_start = 1'b1;
    i_op = op;
    i_rs1_data = a;
    i_rs2_data = b;
    do begin
      step();
      i_start = 1'b0;
      i_op = 3'($urandom);
      i_rs1_data = $urandom;
      i_rs2_data = $urandom;
      lat++;
      if (o_busy) nbusy++;
    end while (!o_valid && lat < 40);
    chk({tag, " latency"}, lat, 34);
    chk({tag, " busy"}, nbusy, 33);
    chk({tag, " result"}, o_result, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int k, nv, k1, k2;
    logic busy_after;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst busy", o_busy, 0);
    chk("rst valid", o_valid, 0);
    chk("rst result", o_result, 0);
    i_reset = 1'b0;
    step();
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    step();
    chk("pulse width", o_valid, 0);
    do_op("mul", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    do_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5);
    do_op("rem0 neg", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    do_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    // start while busy must be ignored
    i_start = 1'b1; i_op = 3'b000; i_rs1_data = 32'd6; i_rs2_data = 32'd7;
    nv = 0; k1 = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      i_start = (i == 10);
      i_op = 3'b101; i_rs1_data = 32'd100; i_rs2_data = 32'd7;
      if (o_valid) begin nv++; k1 = i; end
    end
    i_start = 1'b0;
    chk("ignore nvalid", nv, 1);
    chk("ignore lat", k1, 34);
    chk("ignore result", o_result, 32'd42);
    // back-to-back: start in DONE
    i_start = 1'b1; i_op = 3'b000; i_rs1_data = 32'd3; i_rs2_data = 32'd5;
    k1 = 0; k2 = 0; busy_after = 1'b0;
    for (int i = 1; i <= 80 && k2 == 0; i++) begin
      step();
      i_start = 1'b0;
      if (k1 != 0 && i == k1 + 1) busy_after = o_busy;
      if (o_valid && k1 == 0) begin
        k1 = i;
        chk("b2b first", o_result, 32'd15);
        i_start = 1'b1; i_op = 3'b101; i_rs1_data = 32'd100; i_rs2_data = 32'd7;
      end else if (o_valid) k2 = i;
    end
    chk("b2b no gap", busy_after, 1);
    chk("b2b spacing", k2 - k1, 34);
    chk("b2b second", o_result, 32'd14);
    // flush in CALC
    i_start = 1'b1; i_op = 3'b111; i_rs1_data = 32'd99; i_rs2_data = 32'd10;
    nv = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      i_start = 1'b0;
      i_flush = (i == 15);
      if (o_valid) nv++;
    end
    chk("flush busy", o_busy, 0);
    chk("flush valid", o_valid, 0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_valid) nv++;
    end
    chk("flush nvalid", nv, 0);
    chk("flush result", o_result, 32'd14);
    // flush + start in DONE: pulse stays, start dropped
    i_start = 1'b1; i_op = 3'b000; i_rs1_data = 32'd9; i_rs2_data = 32'd9;
    k = 0;
    do begin
      step();
      i_start = 1'b0;
      k++;
    end while (!o_valid && k < 40);
    chk("dflush valid", o_valid, 1);
    chk("dflush result", o_result, 32'd81);
    i_flush = 1'b1; i_start = 1'b1; i_op = 3'b101;
    step();
    i_flush = 1'b0; i_start = 1'b0;
    chk("dflush busy", o_busy, 0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_valid || o_busy) nv++;
    end
    chk("dflush dropped", nv, 0);
    // reset during FIX
    i_start = 1'b1; i_op = 3'b000; i_rs1_data = 32'd2; i_rs2_data = 32'd3;
    for (int i = 1; i <= 33; i++) begin
      step();
      i_start = 1'b0;
    end
    chk("fix busy", o_busy, 1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("mid rst busy", o_busy, 0);
    chk("mid rst valid", o_valid, 0);
    chk("mid rst result", o_result, 0);
    do_op("post rst", 3'b000, 32'd2, 32'd3, 32'd6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
